// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states, iteration count, divide-by-zero results.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int MDU_ITERS = 32;

    // Divide by zero: LO is all ones, HI passes the dividend through.
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
    localparam logic DIV0_HI_IS_DIVIDEND = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide.
// Purely combinational; the top level registers the accumulator.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_rem;
    logic [WIDTH:0] div_diff;

    // Multiply: add multiplicand to upper half when LSB set, shift right.
    // Divide: shift {rem,quot} left, keep the subtraction if no borrow.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : '0);
        div_rem  = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_rem - {1'b0, opnd};
        acc_next = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// 33-cycle latency: 32 iterations plus one sign-fix cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t state, state_nx;

    logic [4:0]         cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               qsign;
    logic               rsign;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;

    logic               sgn_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;
    logic               take;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .opnd     (op_q[1] ? opb : opa),
        .is_div   (op_q[1]),
        .acc_next (acc_nx)
    );

    // Operand magnitudes and signs captured at launch.
    always_comb begin
        sgn_op = ~op[0];
        a_neg  = sgn_op & a[WIDTH-1];
        b_neg  = sgn_op & b[WIDTH-1];
        a_abs  = a_neg ? -a : a;
        b_abs  = b_neg ? -b : b;
        take   = (state == IDLE) && start;
    end

    // Sign correction and divide-by-zero override for the FIX cycle.
    always_comb begin
        prod   = qsign ? -acc : acc;
        quot   = qsign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = rsign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        hi_fix = prod[2*WIDTH-1:WIDTH];
        lo_fix = prod[WIDTH-1:0];
        if (op_q[1]) begin
            hi_fix = rem;
            lo_fix = quot;
            if (opb == '0) begin
                lo_fix = WIDTH'(DIV0_LO);
                if (DIV0_HI_IS_DIVIDEND) begin
                    hi_fix = rsign ? -opa : opa;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (cnt == 5'(MDU_ITERS - 1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: capture, iterate, and commit results to HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            op_q  <= '0;
            opa   <= '0;
            opb   <= '0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        cnt   <= '0;
                        op_q  <= op;
                        opa   <= a_abs;
                        opb   <= b_abs;
                        qsign <= a_neg ^ b_neg;
                        rsign <= a_neg;
                        acc   <= {{WIDTH{1'b0}}, op[1] ? a_abs : b_abs};
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    hi   <= hi_fix;
                    lo   <= lo_fix;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file. It consumes the two read-port operands (rs on `da`, rt on `db`) and executes MULT, MULTU, DIV and DIVU over multiple cycles. Results go into private HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write. While it works it raises `busy`, so the pipeline control can stall dependent HI/LO accesses.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch an operation; sampled only when `busy`=0.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs operand (multiplicand / dividend), from register-file `da`.
- `b`  in  WIDTH  rt operand (multiplier / divisor), from register-file `db`.
- `mthi`  in  1  write `wdata` into HI.
- `mtlo`  in  1  write `wdata` into LO.
- `wdata`  in  WIDTH  data for MTHI/MTLO.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Reset (async, `rst_n`=0): state IDLE; `hi`, `lo`, `busy`, `done` all 0; iteration counter 0. Assertion mid-operation aborts the operation and discards its result.
- States:
  - IDLE: on `start`, capture `op`, |a|, |b| (absolute values for signed ops; raw for unsigned), and the result signs; counter=0 → RUN.
  - RUN: one iteration per cycle. Multiply is shift-add over a 64-bit accumulator. Divide is restoring, one quotient bit per cycle. After 32 iterations (counter 31 → wraps to 0) → FIX.
  - FIX: apply sign correction, write HI/LO, pulse `done` → IDLE.
- Multiply results: HI:LO = full 64-bit product. Signed product is negated when the operand signs differ.
- Divide results: LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
- Divide by zero (`b`=0): LO = all ones, HI = `a` unchanged, for both DIV and DIVU. Latency unchanged.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Starts that cannot be taken:
  - `start` while `busy`=1 is ignored; there is no queue.
  - `start` in the FIX cycle is ignored (`busy`=1 there).
- MTHI/MTLO:
  - Honoured only in IDLE with `start`=0; the write is visible the next cycle.
  - `mthi` and `mtlo` together in one cycle: both written.
  - `start` together with `mthi`/`mtlo`: start wins, and the move is dropped.
  - `mthi`/`mtlo` while busy: dropped.
- HI/LO keep their previous values throughout RUN; there is no partial-result visibility.

## Timing
- Edge E0 samples `start`=1 → `busy`=1 after E0.
- Edges E1..E32: 32 iterations.
- E33: FIX completes. After E33, `busy`=0, `done`=1 for exactly one cycle, and `hi`/`lo` are valid.
- Start-to-result latency is 33 cycles; `busy` is high for 33 cycles.
- Back-to-back: `start` may be asserted in the `done` cycle. It is sampled at E34, and the next result arrives after E67.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `mdu_pkg` holds:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - state enum IDLE/RUN/FIX;
  - constant `MDU_ITERS`=32;
  - the divide-by-zero result constants.
- Sub-module `mdu_step`: purely combinational single iteration. It takes the accumulator, operand, and mode, and returns the next accumulator. It serves both shift-add and restoring-divide.
- Top level holds the FSM, counter, operand/sign capture, FIX negation, and HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 → after 33 cycles: `done` pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 10/0 → LO=0xFFFFFFFF, HI=0x0000000A, still 33 cycles.
- Second `start` with different operands at cycle 10 of an operation → ignored, first result unchanged. `start` in the `done` cycle → accepted, with its result 33 cycles later.
- MTHI=0x1234 and MTLO=0x5678 in the same IDLE cycle → both visible next cycle. MTHI while busy → HI unchanged at `done`.
- Deassert `rst_n` at cycle 15 of a DIV → `busy`, `done`, `hi`, `lo` all 0 immediately. Neither `done` nor a result appears afterward.
